fpmul_arbiter: RTL

- Shares one fpmul instance among NREQ requesters, each with its own valid/ready request channel and its own result channel.
- Arbitrates round-robin and issues at most one operand pair per cycle into fpmul.
- Tracks each in-flight operation with a tag pipeline that matches the fpmul latency.
- Returns c and over_mul_under to the originating requester through a per-requester result register.

---
 rtl/fpmul_arbiter_pkg.sv | 25 ++
 rtl/fpmul_arbiter_rr.sv | 35 +++
 rtl/fpmul_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/fpmul_arbiter_pkg.sv
// Shared constants and types for the fpmul sharing arbiter.
// Holds the operand width, the default multiplier latency, a couple of
// handy float constants and the in-flight tag record.
package fpmul_arbiter_pkg;

   // IEEE-754 single precision operand width
   localparam int FP_W = 32;

   // Default fpmul latency; must match the real multiplier instance
   localparam int FPMUL_LAT = 3;

   // Common float constants (1.0 and 2.0)
   localparam logic [31:0] FP_ONE = 32'h3F80_0000;
   localparam logic [31:0] FP_TWO = 32'h4000_0000;

   // Requester id field is wide enough for the largest supported NREQ (8)
   localparam int TAG_ID_W = 3;

   // One entry of the tag pipe that follows an operation through fpmul
   typedef struct packed {
      logic                vld;
      logic [TAG_ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/fpmul_arbiter_rr.sv
// Purely combinational round-robin arbiter.
// Grants the first set request bit found searching circularly upward
// from ptr.  Shared by any front end that time-multiplexes an fp unit.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_idx,
   output logic                 any
);

   int cand;

   // Circular priority search starting at ptr; first hit wins
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      cand    = 0;
      for (int off = 0; off < N; off++) begin
         cand = int'(ptr) + off;
         if (cand >= N) begin
            cand = cand - N;
         end
         if (!any && req[cand]) begin
            gnt[cand] = 1'b1;
            gnt_idx   = cand[$clog2(N)-1:0];
            any       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fpmul_arbiter.sv
// Shares one pipelined fpmul among NREQ requesters.
// Each requester has a valid/ready operand channel and its own result
// register.  A round-robin arbiter issues at most one operand pair per
// cycle; a tag pipe running alongside the multiplier remembers who owns
// each product so it can be steered back to the right result register.
// Every requester may have only one operation outstanding at a time.
module fpmul_arbiter
   import fpmul_arbiter_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int MUL_LAT = FPMUL_LAT,
   parameter int W       = FP_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic [NREQ-1:0]   res_valid,
   input  logic [NREQ-1:0]   res_ready,
   output logic [NREQ*W-1:0] res_c,
   output logic [NREQ-1:0]   res_omu,
   output logic [W-1:0]      mul_a,
   output logic [W-1:0]      mul_b,
   input  logic [W-1:0]      mul_c,
   input  logic              mul_omu,
   output logic [NREQ-1:0]   busy
);

   localparam int PW = $clog2(NREQ);

   logic [PW-1:0]   rr_ptr_reg;
   logic [NREQ-1:0] busy_vec;
   logic [NREQ-1:0] elig;
   logic [NREQ-1:0] gnt;
   logic [PW-1:0]   gnt_idx;
   logic            gnt_any;
   logic [W-1:0]    sel_a;
   logic [W-1:0]    sel_b;
   logic [W-1:0]    mul_a_reg;
   logic [W-1:0]    mul_b_reg;
   tag_t            issue_tag;
   tag_t            last_tag;

   // Stage 0 travels with mul_a/mul_b; stage MUL_LAT lines up with the
   // multiplier output, so the capture happens MUL_LAT+1 edges after issue.
   tag_t            tag_reg [MUL_LAT+1];

   // A requester that is still waiting on (or holding) a result is never
   // offered the multiplier again.
   assign elig = req_valid & ~busy_vec;

   rr_arbiter #(
      .N (NREQ)
   ) u_rr (
      .req     (elig),
      .ptr     (rr_ptr_reg),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any     (gnt_any)
   );

   // The grant is the ready; it only ever covers a valid, idle requester,
   // so a grant is always a transfer.
   assign req_ready = gnt;
   assign busy      = busy_vec;

   // Operand mux driven by the winning index
   assign sel_a = req_a[int'(gnt_idx)*W +: W];
   assign sel_b = req_b[int'(gnt_idx)*W +: W];

   // Build the tag that accompanies the operands into the multiplier
   always_comb begin
      issue_tag     = '0;
      issue_tag.vld = gnt_any;
      issue_tag.id  = TAG_ID_W'(gnt_idx);
   end

   // Operand registers feeding fpmul; zeros when nothing is issued
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mul_a_reg <= '0;
         mul_b_reg <= '0;
      end else if (gnt_any) begin
         mul_a_reg <= sel_a;
         mul_b_reg <= sel_b;
      end else begin
         mul_a_reg <= '0;
         mul_b_reg <= '0;
      end
   end

   assign mul_a = mul_a_reg;
   assign mul_b = mul_b_reg;

   // Round-robin pointer moves just past the requester that won
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_reg <= '0;
      end else if (gnt_any) begin
         if (gnt_idx == PW'(NREQ-1)) begin
            rr_ptr_reg <= '0;
         end else begin
            rr_ptr_reg <= gnt_idx + PW'(1);
         end
      end
   end

   // Free-running tag pipe; fpmul has no stall so neither does this.
   // Clearing it on reset drops every in-flight op, which also masks the
   // stale products that drain out of fpmul after reset is released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s <= MUL_LAT; s++) begin
            tag_reg[s] <= '0;
         end
      end else begin
         tag_reg[0] <= issue_tag;
         for (int s = 1; s <= MUL_LAT; s++) begin
            tag_reg[s] <= tag_reg[s-1];
         end
      end
   end

   assign last_tag = tag_reg[MUL_LAT];

   // Per-requester result register and busy flag
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      logic         res_vld_reg;
      logic [W-1:0] res_c_reg;
      logic         res_omu_reg;
      logic         busy_reg;
      logic         capture;
      logic         consume;

      // mul_c/mul_omu are only looked at when a live tag owned by us emerges
      assign capture = last_tag.vld && (last_tag.id == TAG_ID_W'(gi));
      assign consume = res_vld_reg && res_ready[gi];

      // Result capture / consume; data holds after consume until the next
      // product for this requester overwrites it.  Capture and consume
      // cannot coincide because only one op per requester is outstanding.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            res_vld_reg <= 1'b0;
            res_c_reg   <= '0;
            res_omu_reg <= 1'b0;
         end else if (capture) begin
            res_vld_reg <= 1'b1;
            res_c_reg   <= mul_c;
            res_omu_reg <= mul_omu;
         end else if (consume) begin
            res_vld_reg <= 1'b0;
         end
      end

      // Busy from the accept edge until the result is consumed; a new
      // request is therefore accepted no earlier than the following edge.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            busy_reg <= 1'b0;
         end else if (gnt[gi]) begin
            busy_reg <= 1'b1;
         end else if (consume) begin
            busy_reg <= 1'b0;
         end
      end

      assign res_valid[gi]       = res_vld_reg;
      assign res_c[gi*W +: W]    = res_c_reg;
      assign res_omu[gi]         = res_omu_reg;
      assign busy_vec[gi]        = busy_reg;
   end

endmodule
